shift_sequencer: RTL

//  Multi-cycle shift unit controller for the 32-bit multi-cycle CPU datapath.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_sequencer_if.sv | 30 +++
 rtl/shift_step.sv | 24 ++
 rtl/shift_sequencer.sv | 87 ++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift unit: sizes, op codes and FSM states.
package shift_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SHW   = 5;

    // Shift operation encodings as driven by the control unit
    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SHIFT  = 2'b01,
        S_FINISH = 2'b10
    } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the control unit (master) and the shift sequencer (slave).
//   start   : request a shift (accepted only when busy=0)
//   op      : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   shamt   : shift amount, sampled with start
//   operand : value to shift, sampled with start
//   busy    : request in progress
//   done    : one-cycle pulse when result becomes valid
//   result  : shifted value, held until the next accepted request
interface shift_sequencer_if;
    import shift_pkg::*;

    logic             start;
    logic [1:0]       op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] operand;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, shamt, operand,
        input  busy, done, result
    );

    modport slave (
        input  start, op, shamt, operand,
        output busy, done, result
    );

endinterface

// File: rtl/shift_step.sv
// One-bit shift/rotate step of a WIDTH-bit value.
//   r        : current value
//   op       : shift operation (shift_op_e encoding)
//   r_next_c : value after one step (combinational)
module shift_step
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0] r,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] r_next_c
);

    always_comb begin
        r_next_c = r;
        case (op)
            OP_SLL:  r_next_c = {r[WIDTH-2:0], 1'b0};
            OP_SRL:  r_next_c = {1'b0, r[WIDTH-1:1]};
            OP_SRA:  r_next_c = {r[WIDTH-1], r[WIDTH-1:1]};
            OP_ROR:  r_next_c = {r[0], r[WIDTH-1:1]};
            default: r_next_c = r;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: shifts the captured operand one bit per clock
// and pulses done when the result is valid.
//   CLK   : clock
//   reset : asynchronous active-low reset
//   bus   : request/response bundle (slave side)
module shift_sequencer
    import shift_pkg::*;
(
    input  logic              CLK,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);

    state_e           state_q, state_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_c;

    shift_step u_step (
        .r        (result_q),
        .op       (op_q),
        .r_next_c (step_c)
    );

    // State and datapath registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            op_q     <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and next-output logic; busy/done are derived from the next state
    // so they are registered and aligned with the state they describe.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    result_d = bus.operand;
                    op_d     = bus.op;
                    count_d  = bus.shamt;
                    state_d  = (bus.shamt == '0) ? S_FINISH : S_SHIFT;
                end
            end
            S_SHIFT: begin
                result_d = step_c;
                count_d  = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule
